// File: rtl/bsn_row_loader.sv
// bsn_row_loader: packs a word stream into N_INPUTS-wide padded rows for the bitonic sorter, ping-pong buffered.
// Optional BSN_LOADER_SNAKE_EN: row direction alternates with row index parity (snake order).
module bsn_row_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 8,
  parameter int ROW_CNT_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           dir_in,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [N_INPUTS*DATA_WIDTH-1:0] m_data,
  output logic                           m_dir,
  output logic                           m_last,
  output logic [ROW_CNT_W-1:0]           m_row_idx
);
  localparam int SW = $clog2(N_INPUTS);
  localparam int RW = N_INPUTS * DATA_WIDTH;

  logic [1:0][RW-1:0]        buf_data_q, buf_data_d;
  logic [1:0]                buf_dir_q, buf_dir_d;
  logic [1:0]                buf_last_q, buf_last_d;
  logic [1:0][ROW_CNT_W-1:0] buf_idx_q, buf_idx_d;
  logic [1:0]                full_q, full_d;
  logic                      wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [SW-1:0]             slot_q, slot_d;
  logic [ROW_CNT_W-1:0]      row_idx_q, row_idx_d;
  logic                      cur_dir_q, cur_dir_d;
  logic                      accept, close, xfer, dir_now, row_dir;
  logic [DATA_WIDTH-1:0]     pad;

`ifdef BSN_LOADER_SNAKE_EN
  assign dir_now = dir_in ^ row_idx_q[0];
`else
  assign dir_now = dir_in;
`endif

  assign s_ready   = rst && !(&full_q);
  assign m_valid   = |full_q;
  assign m_data    = m_valid ? buf_data_q[rd_sel_q] : '0;
  assign m_dir     = m_valid && buf_dir_q[rd_sel_q];
  assign m_last    = m_valid && buf_last_q[rd_sel_q];
  assign m_row_idx = m_valid ? buf_idx_q[rd_sel_q] : '0;

  always_comb begin
    accept     = s_valid && s_ready;
    close      = accept && (s_last || slot_q == SW'(N_INPUTS - 1));
    xfer       = m_valid && m_ready;
    row_dir    = (slot_q == '0) ? dir_now : cur_dir_q;
    pad        = {DATA_WIDTH{~row_dir}};
    buf_data_d = buf_data_q;
    buf_dir_d  = buf_dir_q;
    buf_last_d = buf_last_q;
    buf_idx_d  = buf_idx_q;
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    slot_d     = slot_q;
    row_idx_d  = row_idx_q;
    cur_dir_d  = cur_dir_q;
    if (accept) begin
      cur_dir_d = row_dir;
      slot_d    = close ? '0 : slot_q + SW'(1);
      for (int i = 0; i < N_INPUTS; i++) begin
        if (i == int'(slot_q))
          buf_data_d[wr_sel_q][i*DATA_WIDTH +: DATA_WIDTH] = s_data;
        else if (close && i > int'(slot_q))
          buf_data_d[wr_sel_q][i*DATA_WIDTH +: DATA_WIDTH] = pad;
      end
    end
    if (close) begin
      buf_dir_d[wr_sel_q]  = row_dir;
      buf_last_d[wr_sel_q] = s_last;
      buf_idx_d[wr_sel_q]  = row_idx_q;
      full_d[wr_sel_q]     = 1'b1;
      wr_sel_d             = ~wr_sel_q;
      row_idx_d            = s_last ? '0 : row_idx_q + ROW_CNT_W'(1);
    end
    // close and transfer never target the same buffer, so both updates compose
    if (xfer) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_data_q <= '0;
      buf_dir_q  <= '0;
      buf_last_q <= '0;
      buf_idx_q  <= '0;
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      slot_q     <= '0;
      row_idx_q  <= '0;
      cur_dir_q  <= 1'b0;
    end else begin
      buf_data_q <= buf_data_d;
      buf_dir_q  <= buf_dir_d;
      buf_last_q <= buf_last_d;
      buf_idx_q  <= buf_idx_d;
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      slot_q     <= slot_d;
      row_idx_q  <= row_idx_d;
      cur_dir_q  <= cur_dir_d;
    end
  end
endmodule

// File: tb/tb_bsn_row_loader.sv
// tb_bsn_row_loader: table vectors, directed corner sequences and random traffic against a row-level queue model.
module tb_bsn_row_loader;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int RW = N * W;
`ifdef BSN_LOADER_SNAKE_EN
  localparam bit SNAKE = 1'b1;
`else
  localparam bit SNAKE = 1'b0;
`endif

  logic clk = 0, rst = 0, dir_in = 0, s_valid = 0, s_last = 0, m_ready = 0;
  logic [W-1:0] s_data = '0;
  logic s_ready, m_valid, m_dir, m_last;
  logic [RW-1:0] m_data;
  logic [7:0] m_row_idx;

  bsn_row_loader #(.DATA_WIDTH(W), .N_INPUTS(N), .ROW_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .dir_in(dir_in), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_dir(m_dir), .m_last(m_last), .m_row_idx(m_row_idx));

  always #5 clk = ~clk;

  typedef struct {logic [RW-1:0] data; logic dir; logic last; logic [7:0] idx;} row_t;
  typedef struct {int n; logic dir; logic last; logic [W-1:0] base; logic [7:0] exp_idx;} vec_t;

  int checks = 0, errors = 0;
  row_t q[$];
  logic [W-1:0] words[$];
  logic cur_dir = 0;
  logic [7:0] ridx = 0;
  logic got_dir[$];

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk_row(input int n, input logic [W-1:0] base, input logic d);
    logic [RW-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = (i < n) ? base + W'(i) : {W{~d}};
    return r;
  endfunction

  // One cycle: drive at negedge, check against the model, then advance the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic di, input logic r);
    bit exp_sr, exp_mv;
    row_t h;
    @(negedge clk);
    s_valid = v; s_data = d; s_last = l; dir_in = di; m_ready = r;
    #1;
    exp_sr = q.size() < 2;
    exp_mv = q.size() > 0;
    chk("s_ready", RW'(s_ready), RW'(exp_sr));
    chk("m_valid", RW'(m_valid), RW'(exp_mv));
    if (exp_mv && r) begin
      h = q.pop_front();
      got_dir.push_back(m_dir);
      chk("m_data", m_data, h.data);
      chk("m_dir", RW'(m_dir), RW'(h.dir));
      chk("m_last", RW'(m_last), RW'(h.last));
      chk("m_row_idx", RW'(m_row_idx), RW'(h.idx));
    end
    if (v && exp_sr) begin
      if (words.size() == 0) cur_dir = di ^ (SNAKE & ridx[0]);
      words.push_back(d);
      if (l || words.size() == N) begin
        h.dir = cur_dir; h.last = l; h.idx = ridx;
        for (int i = 0; i < N; i++) h.data[i*W +: W] = (i < words.size()) ? words[i] : {W{~cur_dir}};
        q.push_back(h);
        words.delete();
        ridx = l ? 8'd0 : ridx + 8'd1;
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) step(0, '0, 0, 0, 1);
    chk("drain_left", RW'(q.size()), RW'(0));
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_m_valid"}, RW'(m_valid), '0);
    chk({nm, "_s_ready"}, RW'(s_ready), '0);
    chk({nm, "_m_data"}, m_data, '0);
    chk({nm, "_m_dir_last"}, RW'({m_dir, m_last}), '0);
    chk({nm, "_m_row_idx"}, RW'(m_row_idx), '0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 0; s_valid = 0;
    #1;
    check_reset_outputs(nm);
    q.delete(); words.delete(); ridx = 0;
    @(negedge clk);
    rst = 1;
  endtask

  vec_t vt[5];
  logic ed;

  initial begin
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1;
    // Table: each row loaded with backpressure, checked while held, then transferred.
    vt[0] = '{8, 1'b0, 1'b0, 32'd1,  8'd0};
    vt[1] = '{3, 1'b0, 1'b1, 32'd5,  8'd1};
    vt[2] = '{3, 1'b1, 1'b1, 32'd5,  8'd0};
    vt[3] = '{1, 1'b1, 1'b1, 32'd9,  8'd0};
    vt[4] = '{8, 1'b1, 1'b0, 32'd20, 8'd0};
    for (int e = 0; e < 5; e++) begin
      for (int j = 0; j < vt[e].n; j++) step(1, vt[e].base + W'(j), vt[e].last && j == vt[e].n - 1, vt[e].dir, 0);
      step(0, '0, 0, 0, 0);
      ed = vt[e].dir ^ (SNAKE & vt[e].exp_idx[0]);
      chk("tbl_valid", RW'(m_valid), RW'(1));
      chk("tbl_data", m_data, mk_row(vt[e].n, vt[e].base, ed));
      chk("tbl_dir", RW'(m_dir), RW'(ed));
      chk("tbl_last", RW'(m_last), RW'(vt[e].last));
      chk("tbl_idx", RW'(m_row_idx), RW'(vt[e].exp_idx));
      step(0, '0, 0, 0, 1);
    end
    // Backpressure: only two rows fit, release later.
    begin
      int k = 0, at30 = 0;
      for (int c = 0; c < 80 && k < 24; c++) begin
        if (c == 30) at30 = k;
        if (q.size() < 2) begin step(1, 100 + W'(k), 0, 0, c >= 30); k++; end
        else step(1, 100 + W'(k), 0, 0, c >= 30);
      end
      chk("bp_accepted_before_release", RW'(at30), RW'(16));
      chk("bp_all_accepted", RW'(k), RW'(24));
      drain();
    end
    // One row pending, next row closes in the same cycle the pending row leaves.
    for (int j = 0; j < 15; j++) step(1, 300 + W'(j), 0, 1, 0);
    step(1, 315, 0, 1, 1);
    chk("same_cycle_pending", RW'(q.size()), RW'(1));
    drain();
    // Async reset at slot 4 of row 2 with a row pending.
    do_reset("pre5");
    for (int j = 0; j < 20; j++) step(1, 500 + W'(j), 0, 0, j <= 8);
    @(negedge clk);
    rst = 0; s_valid = 0;
    #1;
    check_reset_outputs("midrow");
    q.delete(); words.delete(); ridx = 0;
    @(negedge clk);
    rst = 1;
    for (int j = 0; j < 8; j++) step(1, 600 + W'(j), 0, 0, 1);
    drain();
    // Row direction sequence across four full rows.
    do_reset("pre6");
    got_dir.delete();
    for (int j = 0; j < 32; j++) step(1, 700 + W'(j), 0, 0, 1);
    drain();
    chk("dir_rows", RW'(got_dir.size()), RW'(4));
    for (int i = 0; i < 4 && i < got_dir.size(); i++) chk("dir_seq", RW'(got_dir[i]), RW'(SNAKE & i[0]));
    // Random traffic; a pending word is held until accepted.
    begin
      bit have = 0;
      logic [W-1:0] d = '0;
      logic l = 0, di = 0;
      for (int c = 0; c < 3000; c++) begin
        if (!have && $urandom_range(3) != 0) begin
          have = 1; d = $urandom; l = ($urandom_range(5) == 0); di = $urandom_range(1);
        end
        if (have) begin
          if (q.size() < 2) begin step(1, d, l, di, $urandom_range(2) != 0); have = 0; end
          else step(1, d, l, di, $urandom_range(2) != 0);
        end else step(0, $urandom, $urandom_range(1), $urandom_range(1), $urandom_range(2) != 0);
      end
      if (have) for (int c = 0; c < 10 && have; c++) if (q.size() < 2) begin step(1, d, l, di, 1); have = 0; end else step(1, d, l, di, 1);
      step(1, 32'hDEAD, 1, 0, 1);
      drain();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
